// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with start/busy/done handshake and optional excess-3 output coding.
module bcd_seq_converter #(
  parameter int BIN_W   = 8,
  parameter int DIGITS  = 3,
  parameter int EXCESS3 = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
  function automatic bit digits_ok(input int bw, input int nd);
    longint unsigned pow10;
    longint unsigned max_val;
    pow10   = 1;
    max_val = (64'd1 << bw) - 64'd1;
    for (int i = 0; i < nd; i++) begin
      if (pow10 <= max_val) pow10 = pow10 * 10;
    end
    return pow10 > max_val;
  endfunction

  if (BIN_W < 1 || BIN_W > 32) begin : g_bad_width
    $error("bcd_seq_converter: BIN_W=%0d outside 1..32", BIN_W);
  end
  if (!digits_ok(BIN_W, DIGITS)) begin : g_bad_digits
    $error("bcd_seq_converter: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  // Output coding: plain 8421 BCD, or each digit offset by 3 in excess-3 mode.
  function automatic logic [BCD_W-1:0] encode(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    if (EXCESS3 != 0) begin
      for (int k = 0; k < DIGITS; k++) res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    return res;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [BIN_W-1:0] shift_reg;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] scratch_adj;

  // NOTE: assign the default before the loop so no path leaves scratch_adj unassigned (no latch).
  always_comb begin
    scratch_adj = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      scratch   <= '0;
      bcd_out   <= encode('0);
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjust then shift: the MSB of the operand enters the BCD scratch LSB.
          scratch   <= {scratch_adj[BCD_W-2:0], shift_reg[BIN_W-1]};
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state <= FINISH;
        end
        FINISH: begin
          bcd_out <= encode(scratch);
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: three configurations (8-bit BCD, 8-bit excess-3,
// 16-bit BCD), table-driven conversions plus back-to-back, ignored-start and abort sequences.
module tb_bcd_seq_converter;

  typedef struct {
    int          sel;
    logic [31:0] bin;
    logic [19:0] exp;
  } vec_t;

  typedef struct {
    int          sel;
    logic [19:0] val;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [3];
  logic [31:0] bin_v   [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [19:0] bcd_v   [3];
  logic [11:0] bcd0, bcd1;
  logic [19:0] bcd2;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  bcd_seq_converter #(.BIN_W(8), .DIGITS(3), .EXCESS3(0)) u_bcd8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .bin_in(bin_v[0][7:0]),
    .busy(busy_v[0]), .done(done_v[0]), .bcd_out(bcd0));

  bcd_seq_converter #(.BIN_W(8), .DIGITS(3), .EXCESS3(1)) u_xs3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .bin_in(bin_v[1][7:0]),
    .busy(busy_v[1]), .done(done_v[1]), .bcd_out(bcd1));

  bcd_seq_converter #(.BIN_W(16), .DIGITS(5), .EXCESS3(0)) u_bcd16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .bin_in(bin_v[2][15:0]),
    .busy(busy_v[2]), .done(done_v[2]), .bcd_out(bcd2));

  assign bcd_v[0] = {8'h00, bcd0};
  assign bcd_v[1] = {8'h00, bcd1};
  assign bcd_v[2] = bcd2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (done_v[s] === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(s), 32'hFFFF_FFFF);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("done_instance", 32'(s), 32'(e.sel));
          check("bcd_out", 32'(bcd_v[s]), 32'(e.val));
        end
      end
    end
  end

  task automatic run_conv(input int sel, input logic [31:0] b, input logic [19:0] e);
    int cyc;
    int busy_n;
    int w;
    w = (sel == 2) ? 16 : 8;
    @(negedge clk);
    start_v[sel] = 1'b1;
    bin_v[sel]   = b;
    sb_q.push_back('{sel: sel, val: e});
    @(negedge clk);
    start_v[sel] = 1'b0;
    cyc    = 1;
    busy_n = int'(busy_v[sel]);
    while (done_v[sel] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      busy_n += int'(busy_v[sel]);
    end
    check("done_latency", 32'(cyc), 32'(w + 2));
    check("busy_cycles", 32'(busy_n), 32'(w + 1));
    check("busy_at_done", 32'(busy_v[sel]), 32'd0);
    @(negedge clk);
    check("done_drop", 32'(done_v[sel]), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    int cyc;
    int dn;

    tbl[0]  = '{sel: 0, bin: 32'd0,     exp: 20'h00000};
    tbl[1]  = '{sel: 0, bin: 32'd1,     exp: 20'h00001};
    tbl[2]  = '{sel: 0, bin: 32'd9,     exp: 20'h00009};
    tbl[3]  = '{sel: 0, bin: 32'd10,    exp: 20'h00010};
    tbl[4]  = '{sel: 0, bin: 32'd128,   exp: 20'h00128};
    tbl[5]  = '{sel: 1, bin: 32'd99,    exp: 20'h003CC};
    tbl[6]  = '{sel: 1, bin: 32'd0,     exp: 20'h00333};
    tbl[7]  = '{sel: 1, bin: 32'd255,   exp: 20'h00588};
    tbl[8]  = '{sel: 2, bin: 32'd65535, exp: 20'h65535};
    tbl[9]  = '{sel: 2, bin: 32'd40960, exp: 20'h40960};
    tbl[10] = '{sel: 2, bin: 32'd9999,  exp: 20'h09999};
    tbl[11] = '{sel: 2, bin: 32'd0,     exp: 20'h00000};

    for (int s = 0; s < 3; s++) begin
      start_v[s] = 1'b0;
      bin_v[s]   = '0;
    end

    repeat (3) @(negedge clk);
    check("rst_busy8", 32'(busy_v[0]), 32'd0);
    check("rst_done8", 32'(done_v[0]), 32'd0);
    check("rst_bcd8", 32'(bcd_v[0]), 32'h000);
    check("rst_bcd_xs3", 32'(bcd_v[1]), 32'h333);
    check("rst_bcd16", 32'(bcd_v[2]), 32'h00000);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run_conv(tbl[i].sel, tbl[i].bin, tbl[i].exp);

    // Back-to-back: start held through the done cycle launches the next conversion.
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 32'd255;
    sb_q.push_back('{sel: 0, val: 20'h00255});
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done_v[0] !== 1'b1 && cyc < 100);
    check("b2b_first_latency", 32'(cyc), 32'd10);
    bin_v[0] = 32'd100;
    sb_q.push_back('{sel: 0, val: 20'h00100});
    @(negedge clk);
    start_v[0] = 1'b0;
    check("b2b_restart_busy", 32'(busy_v[0]), 32'd1);
    cyc = 1;
    while (done_v[0] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_gap", 32'(cyc), 32'd10);
    @(negedge clk);

    // start while busy must be ignored: one done pulse, original operand's result.
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 32'd37;
    sb_q.push_back('{sel: 0, val: 20'h00037});
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 32'd200;
    @(negedge clk);
    start_v[0] = 1'b0;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) dn++;
    end
    check("ignore_done_count", 32'(dn), 32'd1);

    // Reset mid-conversion aborts: outputs return to reset values, no done pulse.
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 32'd255;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_bcd8", 32'(bcd_v[0]), 32'h000);
    check("abort_busy8", 32'(busy_v[0]), 32'd0);
    check("abort_done8", 32'(done_v[0]), 32'd0);
    check("abort_bcd_xs3", 32'(bcd_v[1]), 32'h333);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    check("abort_bcd_hold", 32'(bcd_v[0]), 32'h000);
    run_conv(0, 32'd58, 20'h00058);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
